// File: rtl/case4_sweep_checker_if.sv
// Bundle of the sweep-control, stimulus, response and result signals of case4_sweep_checker.
// The checker connects as slave; whatever drives start/abort and feeds resp back connects as master.
interface case4_sweep_checker_if;
    logic       start;
    logic       abort;
    logic [6:0] stim;
    logic [2:0] resp;
    logic       busy;
    logic       done;
    logic       pass;
    logic [7:0] err_count;
    logic [2:0] fail_xyz;
    logic [6:0] first_fail_vec;
    logic       first_fail_valid;

    modport master (
        output start, abort, resp,
        input  stim, busy, done, pass, err_count, fail_xyz, first_fail_vec, first_fail_valid
    );

    modport slave (
        input  start, abort, resp,
        output stim, busy, done, pass, err_count, fail_xyz, first_fail_vec, first_fail_valid
    );
endinterface

// File: rtl/case4_sweep_checker.sv
// Exhaustive 128-vector sweep of the case4 block: drives stim, samples resp SETTLE cycles
// later, compares against the golden x/y/z functions and keeps error statistics.
module case4_sweep_checker #(
    parameter int unsigned SETTLE = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    case4_sweep_checker_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HOLD = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [3:0] SETTLE_C = 4'(SETTLE);
    localparam logic [6:0] LAST_VEC = 7'd127;

    state_t     state_q;
    logic [6:0] stim_q;
    logic [3:0] cnt_q;
    logic       busy_q;
    logic       done_q;
    logic       pass_q;
    logic [7:0] err_count_q;
    logic [2:0] fail_xyz_q;
    logic [6:0] first_fail_vec_q;
    logic       first_fail_valid_q;

    logic [2:0] golden;
    logic [2:0] diff;
    logic       mismatch;
    logic       sample_now;
    logic       launch;
    logic       last_vec;
    logic [7:0] err_count_d;
    logic [2:0] fail_xyz_d;

    // stim is the vector index while sweeping, so the model evaluates what the DUT currently sees.
    always_comb begin
        golden[2] = stim_q[6] & stim_q[5] & stim_q[2];
        golden[1] = ~(stim_q[5] & stim_q[3] & stim_q[2]);
        golden[0] = ~(stim_q[4] & stim_q[3] & stim_q[2] & stim_q[1] & stim_q[0]);
    end

    for (genvar gi = 0; gi < 3; gi++) begin : g_diff
        assign diff[gi] = bus.resp[gi] ^ golden[gi];
    end

    always_comb begin
        mismatch    = |diff;
        sample_now  = (state_q == S_HOLD) && (cnt_q == SETTLE_C);
        launch      = bus.start && (state_q != S_HOLD);
        last_vec    = (stim_q == LAST_VEC);
        err_count_d = err_count_q + {7'd0, mismatch};
        fail_xyz_d  = fail_xyz_q | diff;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q            <= S_IDLE;
            stim_q             <= '0;
            cnt_q              <= '0;
            busy_q             <= 1'b0;
            done_q             <= 1'b0;
            pass_q             <= 1'b0;
            err_count_q        <= '0;
            fail_xyz_q         <= '0;
            first_fail_vec_q   <= '0;
            first_fail_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (launch) begin
                        state_q            <= S_HOLD;
                        stim_q             <= '0;
                        cnt_q              <= '0;
                        busy_q             <= 1'b1;
                        done_q             <= 1'b0;
                        pass_q             <= 1'b0;
                        err_count_q        <= '0;
                        fail_xyz_q         <= '0;
                        first_fail_vec_q   <= '0;
                        first_fail_valid_q <= 1'b0;
                    end
                end
                S_HOLD: begin
                    // Abort leaves partial statistics visible; done stays low so they are not qualified.
                    if (bus.abort) begin
                        state_q <= S_IDLE;
                        stim_q  <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end else if (sample_now) begin
                        cnt_q <= '0;
                        if (mismatch) begin
                            err_count_q <= err_count_d;
                            fail_xyz_q  <= fail_xyz_d;
                            if (!first_fail_valid_q) begin
                                first_fail_vec_q   <= stim_q;
                                first_fail_valid_q <= 1'b1;
                            end
                        end
                        if (last_vec) begin
                            state_q <= S_DONE;
                            stim_q  <= '0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            pass_q  <= (err_count_d == 8'd0);
                        end else begin
                            stim_q <= stim_q + 7'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    stim_q  <= '0;
                end
            endcase
        end
    end

    assign bus.stim             = stim_q;
    assign bus.busy             = busy_q;
    assign bus.done             = done_q;
    assign bus.pass             = pass_q;
    assign bus.err_count        = err_count_q;
    assign bus.fail_xyz         = fail_xyz_q;
    assign bus.first_fail_vec   = first_fail_vec_q;
    assign bus.first_fail_valid = first_fail_valid_q;

endmodule

// File: tb/tb_case4_sweep_checker.sv
// Directed bench for case4_sweep_checker: a combinational DUT stand-in with selectable faults
// on SETTLE=0, and a three-register-stage DUT stand-in checked with SETTLE=3 and SETTLE=2.
module tb_case4_sweep_checker;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;
    int   mode;   // 0: golden, 1: resp tied 111, 2: x inverted at 0x5A

    case4_sweep_checker_if if0();
    case4_sweep_checker_if if3();
    case4_sweep_checker_if if2();

    case4_sweep_checker #(.SETTLE(0)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    case4_sweep_checker #(.SETTLE(3)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(if3));
    case4_sweep_checker #(.SETTLE(2)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2:0] case4_ref(input logic [6:0] v);
        logic a, b, c, d, e, f, g;
        {a, b, c, d, e, f, g} = v;
        return {a & b & e, ~(b & d & e), ~(c & d & e & f & g)};
    endfunction

    always_comb begin
        if0.resp = case4_ref(if0.stim);
        if (mode == 1)
            if0.resp = 3'b111;
        else if (mode == 2 && if0.stim == 7'h5A)
            if0.resp = case4_ref(if0.stim) ^ 3'b100;
    end

    // Three-stage pipelined DUT stand-ins.
    logic [2:0] p3_1, p3_2, p3_3, p2_1, p2_2, p2_3;
    always_ff @(posedge clk) begin
        p3_1 <= case4_ref(if3.stim);
        p3_2 <= p3_1;
        p3_3 <= p3_2;
        p2_1 <= case4_ref(if2.stim);
        p2_2 <= p2_1;
        p2_3 <= p2_2;
    end
    assign if3.resp = p3_3;
    assign if2.resp = p2_3;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end else begin
            $display("check %s: 0x%0h ok", tag, obs);
        end
    endtask

    function automatic logic busy_of(input int sel);
        case (sel)
            0:       return if0.busy;
            3:       return if3.busy;
            default: return if2.busy;
        endcase
    endfunction

    task automatic set_start(input int sel, input logic v);
        case (sel)
            0:       if0.start = v;
            3:       if3.start = v;
            default: if2.start = v;
        endcase
    endtask

    // Called #1 after a rising edge; returns #1 after the edge that ends the sweep.
    // restart_at >= 0 pulses start again that many cycles into the sweep.
    task automatic run_sweep(input int sel, input int restart_at, output int busy_cycles);
        set_start(sel, 1'b1);
        @(posedge clk); #1;
        set_start(sel, 1'b0);
        busy_cycles = 0;
        while (busy_of(sel) && busy_cycles < 5000) begin
            set_start(sel, busy_cycles == restart_at);
            @(posedge clk); #1;
            busy_cycles++;
        end
        set_start(sel, 1'b0);
    endtask

    task automatic check_reset_vals(input string pfx);
        check_val({pfx, "_stim"},   32'(if0.stim), 32'h0);
        check_val({pfx, "_busy"},   32'(if0.busy), 32'h0);
        check_val({pfx, "_done"},   32'(if0.done), 32'h0);
        check_val({pfx, "_pass"},   32'(if0.pass), 32'h0);
        check_val({pfx, "_errcnt"}, 32'(if0.err_count), 32'h0);
        check_val({pfx, "_failxyz"}, 32'(if0.fail_xyz), 32'h0);
        check_val({pfx, "_ffvec"},  32'(if0.first_fail_vec), 32'h0);
        check_val({pfx, "_ffvalid"}, 32'(if0.first_fail_valid), 32'h0);
    endtask

    initial begin
        int cyc;
        n_checks = 0;
        n_errors = 0;
        mode     = 0;
        rst_n    = 1'b0;
        if0.start = 1'b0; if0.abort = 1'b0;
        if3.start = 1'b0; if3.abort = 1'b0;
        if2.start = 1'b0; if2.abort = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("rst");
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_val("idle_busy", 32'(if0.busy), 32'h0);

        // Golden combinational DUT
        mode = 0;
        run_sweep(0, -1, cyc);
        check_val("gold_busy_cycles", 32'(cyc), 32'd128);
        check_val("gold_done", 32'(if0.done), 32'h1);
        check_val("gold_pass", 32'(if0.pass), 32'h1);
        check_val("gold_errcnt", 32'(if0.err_count), 32'd0);
        check_val("gold_failxyz", 32'(if0.fail_xyz), 32'h0);
        check_val("gold_ffvalid", 32'(if0.first_fail_valid), 32'h0);
        check_val("gold_stim_done", 32'(if0.stim), 32'h0);

        // abort in DONE is ignored
        if0.abort = 1'b1;
        @(posedge clk); #1;
        if0.abort = 1'b0;
        check_val("abort_in_done_done", 32'(if0.done), 32'h1);

        // resp stuck at 111
        mode = 1;
        run_sweep(0, -1, cyc);
        check_val("stuck_errcnt", 32'(if0.err_count), 32'd120);
        check_val("stuck_failxyz", 32'(if0.fail_xyz), 32'h7);
        check_val("stuck_ffvec", 32'(if0.first_fail_vec), 32'h00);
        check_val("stuck_ffvalid", 32'(if0.first_fail_valid), 32'h1);
        check_val("stuck_pass", 32'(if0.pass), 32'h0);
        check_val("stuck_done", 32'(if0.done), 32'h1);

        // single x fault at 0x5A
        mode = 2;
        run_sweep(0, -1, cyc);
        check_val("x5a_errcnt", 32'(if0.err_count), 32'd1);
        check_val("x5a_failxyz", 32'(if0.fail_xyz), 32'h4);
        check_val("x5a_ffvec", 32'(if0.first_fail_vec), 32'h5A);
        check_val("x5a_ffvalid", 32'(if0.first_fail_valid), 32'h1);
        check_val("x5a_pass", 32'(if0.pass), 32'h0);

        // three-stage DUT, SETTLE = 3 and SETTLE = 2
        run_sweep(3, -1, cyc);
        check_val("pipe3_busy_cycles", 32'(cyc), 32'd512);
        check_val("pipe3_pass", 32'(if3.pass), 32'h1);
        check_val("pipe3_errcnt", 32'(if3.err_count), 32'd0);
        run_sweep(2, -1, cyc);
        check_val("pipe2_busy_cycles", 32'(cyc), 32'd384);
        check_val("pipe2_pass", 32'(if2.pass), 32'h0);
        check_val("pipe2_errcnt_nonzero", 32'(if2.err_count != 8'd0), 32'h1);
        check_val("pipe2_done", 32'(if2.done), 32'h1);

        // abort 50 cycles into a sweep
        mode = 0;
        if0.start = 1'b1;
        @(posedge clk); #1;
        if0.start = 1'b0;
        repeat (49) @(posedge clk);
        #1;
        check_val("pre_abort_busy", 32'(if0.busy), 32'h1);
        if0.abort = 1'b1;
        if0.start = 1'b1;
        @(posedge clk); #1;
        if0.abort = 1'b0;
        if0.start = 1'b0;
        check_val("abort_busy", 32'(if0.busy), 32'h0);
        check_val("abort_done", 32'(if0.done), 32'h0);
        check_val("abort_stim", 32'(if0.stim), 32'h0);
        check_val("abort_pass", 32'(if0.pass), 32'h0);
        run_sweep(0, -1, cyc);
        check_val("post_abort_busy_cycles", 32'(cyc), 32'd128);
        check_val("post_abort_pass", 32'(if0.pass), 32'h1);

        // start pulsed mid-sweep is ignored
        run_sweep(0, 60, cyc);
        check_val("restart_busy_cycles", 32'(cyc), 32'd128);
        check_val("restart_pass", 32'(if0.pass), 32'h1);

        // asynchronous reset mid-sweep
        mode = 1;
        if0.start = 1'b1;
        @(posedge clk); #1;
        if0.start = 1'b0;
        repeat (70) @(posedge clk);
        #3;
        check_val("pre_rst_errcnt_nonzero", 32'(if0.err_count != 8'd0), 32'h1);
        rst_n = 1'b0;
        #1;
        check_reset_vals("async_rst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_val("after_rst_idle_busy", 32'(if0.busy), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
